// File: rtl/led_frame_loader.sv
// Byte-stream loader for a double-buffered NUM_LEDS x 3 byte LED frame store.
// Define LED_COLOR_MAP_EN to map stream R,G,B order onto each LED's physical sink order.
module led_frame_loader #(
  parameter int unsigned NUM_LEDS   = 11,
  parameter logic [7:0]  HDR_BASE   = 8'h80,
  parameter logic [7:0]  CMD_COMMIT = 8'hC0
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       frame_sync,
  input  logic [3:0] rd_led,
  input  logic [1:0] rd_slot,
  output logic [7:0] rd_value,
  output logic       busy,
  output logic       commit_done,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LastLed = 4'(NUM_LEDS - 1);
  localparam logic [8:0] HdrEnd  = {1'b0, HDR_BASE} + 9'(NUM_LEDS);

  typedef enum logic [2:0] {StIdle, StD0, StD1, StD2, StWaitSync, StCopy} state_e;

  state_e     state_q, state_d;
  logic       bank_q, bank_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d;

  // mem_q[bank_q] is displayed; mem_q[~bank_q] is the shadow being written.
  logic [7:0] mem_q [2][NUM_LEDS][3];

  logic       xfer, is_hdr, wr_en, cp_en, shd;
  logic [1:0] data_k, wr_slot;

  assign xfer   = in_valid && in_ready;
  assign is_hdr = ({1'b0, in_data} >= {1'b0, HDR_BASE}) && ({1'b0, in_data} < HdrEnd);
  assign shd    = ~bank_q;

`ifdef LED_COLOR_MAP_EN
  always_comb begin
    wr_slot = data_k;
    unique case (idx_q)
      4'd1, 4'd3, 4'd5, 4'd6: wr_slot = 2'd2 - data_k;
      4'd7, 4'd8:             wr_slot = (data_k == 2'd2) ? 2'd2 : {1'b0, ~data_k[0]};
      default: ;
    endcase
  end
`else
  assign wr_slot = data_k;
`endif

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    cp_en   = 1'b0;
    data_k  = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (is_hdr) begin
            idx_d   = 4'(in_data - HDR_BASE);
            state_d = StD0;
          end else if (in_data == CMD_COMMIT) begin
            state_d = StWaitSync;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      StD0: begin
        data_k = 2'd0;
        if (xfer) begin
          wr_en   = 1'b1;
          state_d = StD1;
        end
      end
      StD1: begin
        data_k = 2'd1;
        if (xfer) begin
          wr_en   = 1'b1;
          state_d = StD2;
        end
      end
      StD2: begin
        data_k = 2'd2;
        if (xfer) begin
          wr_en   = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitSync: begin
        if (frame_sync) begin
          bank_d  = ~bank_q;
          cnt_d   = 4'd0;
          state_d = StCopy;
        end
      end
      StCopy: begin
        cp_en = 1'b1;
        if (cnt_q == LastLed) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      bank_q  <= 1'b0;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Copy-back runs after the swap, so it reads the newly displayed bank.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < NUM_LEDS; l++) begin
          for (int s = 0; s < 3; s++) begin
            mem_q[b][l][s] <= 8'h00;
          end
        end
      end
    end else if (wr_en) begin
      mem_q[shd][idx_q][wr_slot] <= in_data;
    end else if (cp_en) begin
      for (int s = 0; s < 3; s++) begin
        mem_q[shd][cnt_q][s] <= mem_q[bank_q][cnt_q][s];
      end
    end
  end

  assign rd_value    = (rd_led <= LastLed && rd_slot != 2'd3) ?
                       mem_q[bank_q][rd_led][rd_slot] : 8'h00;
  assign in_ready    = (state_q != StWaitSync) && (state_q != StCopy);
  assign busy        = (state_q == StWaitSync) || (state_q == StCopy);
  assign commit_done = (state_q == StCopy) && (cnt_q == 4'd0);
  assign err_cnt     = err_q;

endmodule
